// File: rtl/sp_sram_rr_arbiter_pkg.sv
// Shared constants for the two-requester single-port SRAM arbiter.
package sp_sram_rr_arbiter_pkg;
   localparam int REQ_M0 = 0;
   localparam int REQ_M1 = 1;
   localparam int SRAM_ADDR_WIDTH = 11;
   localparam int SRAM_DATA_WIDTH = 8;
endpackage

// File: rtl/sp_sram_rr_arbiter_rr_pick2.sv
// Combinational 2-way picker: lock holder first, then lone requester,
// then fixed (m0) or round-robin tie-break against last_owner.
module sp_sram_rr_arbiter_rr_pick2 #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic [1:0] req,
   input  logic       last_owner,
   input  logic       lock_valid,
   input  logic       lock_owner,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (lock_valid && req[lock_owner]) begin
         gnt[lock_owner] = 1'b1;
      end else if (req == 2'b01) begin
         gnt = 2'b01;
      end else if (req == 2'b10) begin
         gnt = 2'b10;
      end else if (req == 2'b11) begin
         // last_owner == m1 means m0 is next in rotation
         if (FIXED_PRIO || last_owner) gnt = 2'b01;
         else                          gnt = 2'b10;
      end
   end

endmodule

// File: rtl/sp_sram_rr_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port byte SRAM with
// one-cycle registered read; per-requester read-valid strobe and optional lock.
module sp_sram_rr_arbiter
   import sp_sram_rr_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic                  m0_lock,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic                  m1_lock,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  sram_cs,
   output logic                  sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_data,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   logic       last_owner;
   logic       lock_valid;
   logic       lock_owner;
   logic [1:0] rd_pend;
   logic [1:0] req;
   logic [1:0] gnt_pick;
   logic [1:0] gnt;
   logic [1:0] we;
   logic       sel;
   logic       sel_lock;

   assign req = {m1_req, m0_req};
   assign we  = {m1_we, m0_we};

   sp_sram_rr_arbiter_rr_pick2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .lock_valid (lock_valid),
      .lock_owner (lock_owner),
      .gnt        (gnt_pick)
   );

   // Grant is suppressed while reset is asserted so the SRAM deselects at once
   assign gnt      = rst ? 2'b00 : gnt_pick;
   assign m0_gnt   = gnt[REQ_M0];
   assign m1_gnt   = gnt[REQ_M1];
   assign sel      = gnt[REQ_M1];
   assign sel_lock = sel ? m1_lock : m0_lock;

   always_comb begin
      sram_cs   = 1'b0;
      sram_wen  = 1'b1;
      sram_addr = '0;
      sram_data = '0;
      if (|gnt) begin
         sram_cs   = 1'b1;
         sram_wen  = ~we[sel];
         sram_addr = sel ? m1_addr  : m0_addr;
         sram_data = sel ? m1_wdata : m0_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner <= 1'b1;
         lock_valid <= 1'b0;
         lock_owner <= 1'b0;
         rd_pend    <= 2'b00;
      end else begin
         rd_pend <= gnt & ~we;
         if (|gnt) begin
            last_owner <= sel;
            lock_valid <= sel_lock;
            lock_owner <= sel;
         end else if (lock_valid && !req[lock_owner]) begin
            lock_valid <= 1'b0;
         end
      end
   end

   assign m0_rvalid = rd_pend[REQ_M0];
   assign m1_rvalid = rd_pend[REQ_M1];
   assign m0_rdata  = rd_pend[REQ_M0] ? sram_q : '0;
   assign m1_rdata  = rd_pend[REQ_M1] ? sram_q : '0;

endmodule

// File: tb/tb_sp_sram_rr_arbiter.sv
// Scoreboard bench for sp_sram_rr_arbiter: directed accesses push expected
// read data, a negedge monitor pops and compares on every rvalid.
module tb_sp_sram_rr_arbiter;

   localparam int AW = 11;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          sram_cs, sram_wen;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_data, sram_q;

   logic          fp_m0_req, fp_m0_gnt, fp_m0_rvalid;
   logic          fp_m1_req, fp_m1_gnt, fp_m1_rvalid;
   logic [DW-1:0] fp_m0_rdata, fp_m1_rdata, fp_q;
   logic          fp_cs, fp_wen;
   logic [AW-1:0] fp_addr;
   logic [DW-1:0] fp_data;

   sp_sram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .sram_cs(sram_cs), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_data(sram_data), .sram_q(sram_q)
   );

   sp_sram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_req(fp_m0_req), .m0_we(1'b0), .m0_lock(1'b0), .m0_addr(11'h010),
      .m0_wdata(8'h00), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
      .m1_req(fp_m1_req), .m1_we(1'b0), .m1_lock(1'b0), .m1_addr(11'h020),
      .m1_wdata(8'h00), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
      .sram_cs(fp_cs), .sram_wen(fp_wen), .sram_addr(fp_addr),
      .sram_data(fp_data), .sram_q(fp_q)
   );

   // Behavioural 2048x8 SRAM: write on cs & ~wen, registered read otherwise
   logic [DW-1:0] mem [0:2047];
   always @(posedge clk) begin
      if (sram_cs) begin
         if (!sram_wen) mem[sram_addr] <= sram_data;
         else           sram_q <= mem[sram_addr];
      end
   end

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0;
   exp_t e1;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m0_rvalid === 1'b1) begin
         if (q0.size() == 0) chk("m0_unexpected_rvalid", 32'd1, 32'd0);
         else begin
            e0 = q0.pop_front();
            chk("m0_rdata", m0_rdata, e0.data);
            chk("m0_rvalid_cycle", cyc, e0.cyc);
         end
      end
      if (m1_rvalid === 1'b1) begin
         if (q1.size() == 0) chk("m1_unexpected_rvalid", 32'd1, 32'd0);
         else begin
            e1 = q1.pop_front();
            chk("m1_rdata", m1_rdata, e1.data);
            chk("m1_rvalid_cycle", cyc, e1.cyc);
         end
      end
   end

   task automatic step(input string tag,
                       input logic r0, input logic w0, input logic l0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic eg0, input logic eg1,
                       input logic [DW-1:0] x0, input logic [DW-1:0] x1);
      @(negedge clk);
      m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
      #2;
      chk({tag, "_m0_gnt"}, {31'd0, m0_gnt}, {31'd0, eg0});
      chk({tag, "_m1_gnt"}, {31'd0, m1_gnt}, {31'd0, eg1});
      if (eg0 && !w0) q0.push_back('{x0, cyc + 1});
      if (eg1 && !w1) q1.push_back('{x1, cyc + 1});
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      mem[11'h010] = 8'h3C;
      mem[11'h020] = 8'h5A;
      mem[11'h030] = 8'h77;
      mem[11'h100] = 8'h11;
      mem[11'h101] = 8'h22;
      mem[11'h102] = 8'h33;
      mem[11'h103] = 8'h44;
      fp_q = 8'h00;
      fp_m0_req = 1'b0;
      fp_m1_req = 1'b0;

      // Requests held high during reset must not reach the SRAM
      idle_inputs();
      m0_req = 1'b1; m0_addr = 11'h123; m0_wdata = 8'hEE;
      m1_req = 1'b1; m1_addr = 11'h456;
      #12;
      chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      chk("rst_sram_cs", {31'd0, sram_cs}, 32'd0);
      chk("rst_sram_wen", {31'd0, sram_wen}, 32'd1);
      chk("rst_sram_addr", {21'd0, sram_addr}, 32'd0);
      chk("rst_sram_data", {24'd0, sram_data}, 32'd0);
      chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
      chk("rst_m1_rdata", {24'd0, m1_rdata}, 32'd0);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;

      // First contention after reset goes to m0, then rotates to m1
      step("rr0", 1,0,0,11'h010,8'h00, 1,0,0,11'h020,8'h00, 1,0, 8'h3C,8'h00);
      step("rr1", 1,0,0,11'h010,8'h00, 1,0,0,11'h020,8'h00, 0,1, 8'h00,8'h5A);

      step("wr", 1,1,0,11'h7FF,8'hA5, 0,0,0,11'h000,8'h00, 1,0, 8'h00,8'h00);
      chk("wr_sram_cs", {31'd0, sram_cs}, 32'd1);
      chk("wr_sram_wen", {31'd0, sram_wen}, 32'd0);
      chk("wr_sram_addr", {21'd0, sram_addr}, 32'h7FF);
      chk("wr_sram_data", {24'd0, sram_data}, 32'hA5);
      step("rd_new", 1,0,0,11'h7FF,8'h00, 0,0,0,11'h000,8'h00, 1,0, 8'hA5,8'h00);
      chk("rd_sram_wen", {31'd0, sram_wen}, 32'd1);
      chk("rd_sram_addr", {21'd0, sram_addr}, 32'h7FF);
      step("idle", 0,0,0,11'h155,8'h66, 0,0,0,11'h2AA,8'h99, 0,0, 8'h00,8'h00);
      chk("idle_sram_cs", {31'd0, sram_cs}, 32'd0);
      chk("idle_sram_wen", {31'd0, sram_wen}, 32'd1);
      chk("idle_sram_addr", {21'd0, sram_addr}, 32'd0);
      chk("idle_sram_data", {24'd0, sram_data}, 32'd0);

      // Lock burst: m1 stalled for four m0 accesses, then served
      step("m1only", 0,0,0,11'h000,8'h00, 1,0,0,11'h020,8'h00, 0,1, 8'h00,8'h5A);
      step("lk0", 1,0,1,11'h100,8'h00, 1,0,0,11'h030,8'h00, 1,0, 8'h11,8'h00);
      step("lk1", 1,0,1,11'h101,8'h00, 1,0,0,11'h030,8'h00, 1,0, 8'h22,8'h00);
      step("lk2", 1,0,1,11'h102,8'h00, 1,0,0,11'h030,8'h00, 1,0, 8'h33,8'h00);
      step("lk3", 1,0,0,11'h103,8'h00, 1,0,0,11'h030,8'h00, 1,0, 8'h44,8'h00);
      step("after_lk", 1,0,0,11'h010,8'h00, 1,0,0,11'h030,8'h00, 0,1, 8'h00,8'h77);

      // Lock owner drops req: the other side is granted in the same cycle
      step("lk_set", 1,0,1,11'h101,8'h00, 0,0,0,11'h000,8'h00, 1,0, 8'h22,8'h00);
      step("lk_drop", 0,0,0,11'h000,8'h00, 1,0,0,11'h030,8'h00, 0,1, 8'h00,8'h77);

      // Reset right after a granted read: its rvalid must never appear
      @(negedge clk);
      idle_inputs();
      m0_req = 1'b1; m0_addr = 11'h010;
      #2;
      chk("prerst_m0_gnt", {31'd0, m0_gnt}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      m1_req = 1'b1; m1_addr = 11'h020;
      #1;
      chk("midrst_sram_cs", {31'd0, sram_cs}, 32'd0);
      chk("midrst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      chk("midrst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      @(negedge clk);
      chk("midrst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
      chk("midrst_m0_rdata", {24'd0, m0_rdata}, 32'd0);
      idle_inputs();
      rst = 1'b0;
      step("post_rst0", 1,0,0,11'h010,8'h00, 1,0,0,11'h020,8'h00, 1,0, 8'h3C,8'h00);
      step("post_rst1", 1,0,0,11'h010,8'h00, 1,0,0,11'h020,8'h00, 0,1, 8'h00,8'h5A);

      // Fixed-priority instance: m0 wins every cycle under constant contention
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         fp_m0_req = 1'b1;
         fp_m1_req = 1'b1;
         #2;
         chk("fp_m0_gnt", {31'd0, fp_m0_gnt}, 32'd1);
         chk("fp_m1_gnt", {31'd0, fp_m1_gnt}, 32'd0);
      end
      @(negedge clk);
      fp_m0_req = 1'b0;
      fp_m1_req = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("m0_queue_drained", q0.size(), 32'd0);
      chk("m1_queue_drained", q1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
